// File: rtl/rr_output_arbiter.sv
// rr_output_arbiter: wormhole round-robin arbiter for one router output port.
// Picks one of N_IN first-word-fall-through FIFOs, holds the grant until the
// tail flit (bit FLIT_W-1) is popped, and streams flits through a registered
// valid/ready stage.
// Optional build macro: ARB_TIMEOUT_EN adds a stall watchdog that releases a
// grant whose FIFO stays empty for TIMEOUT_CYC cycles and pulses err_timeout.
// Without it the grant is held indefinitely and err_timeout is always 0.
module rr_output_arbiter #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned FLIT_W      = 9,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          fifo_empty,
  input  logic [N_IN*FLIT_W-1:0]   fifo_rdata,
  output logic [N_IN-1:0]          fifo_rinc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLIT_W-1:0]        out_data,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_ptr_nxt;
  logic [ID_W-1:0]   grant_nxt;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   gnt_inc;
  logic              pick_vld;
  logic [FLIT_W-1:0] head_flit;
  logic [FLIT_W-1:0] data_nxt;
  logic              gnt_empty;
  logic              load;
  logic              valid_nxt;
  logic              err_nxt;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned    CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_nxt;
`endif

  // Head flit and empty flag of the currently granted FIFO
  always_comb begin
    head_flit = '0;
    gnt_empty = 1'b1;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (grant_id == ID_W'(i)) begin
        head_flit = fifo_rdata[i*FLIT_W +: FLIT_W];
        gnt_empty = fifo_empty[i];
      end
    end
  end

  // Round-robin search: first non-empty FIFO starting at rr_ptr
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = rr_ptr;
    for (int unsigned k = 0; k < N_IN; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!pick_vld && !fifo_empty[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  // Pointer value that follows the current grant, wrapping at N_IN-1
  assign gnt_inc = (grant_id == ID_W'(N_IN - 1)) ? '0 : ID_W'(grant_id + ID_W'(1));

  // A flit moves from the granted FIFO into the output register
  assign load = (state == ST_BUSY) && !rst && !gnt_empty && (!out_valid || out_ready);

  // One-hot pop strobe, only toward the granted FIFO on a load
  always_comb begin
    fifo_rinc = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (load && (grant_id == ID_W'(i))) fifo_rinc[i] = 1'b1;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    valid_nxt  = out_valid;
    data_nxt   = out_data;
    err_nxt    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    stall_nxt  = '0;
`endif

    if (out_valid && out_ready) valid_nxt = 1'b0;
    if (load) begin
      valid_nxt = 1'b1;
      data_nxt  = head_flit;
    end

    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_id;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (load) begin
          if (head_flit[FLIT_W-1]) begin
            state_nxt  = ST_IDLE;
            rr_ptr_nxt = gnt_inc;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (gnt_empty) begin
          if (stall_cnt == STALL_MAX) begin
            state_nxt  = ST_IDLE;
            rr_ptr_nxt = gnt_inc;
            err_nxt    = 1'b1;
          end else begin
            stall_nxt = stall_cnt + CNT_W'(1);
          end
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, arbitration and output-stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant_id    <= grant_nxt;
      out_valid   <= valid_nxt;
      out_data    <= data_nxt;
      err_timeout <= err_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Consecutive empty-while-granted cycle counter
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else     stall_cnt <= stall_nxt;
  end
`endif

  assign busy = (state == ST_BUSY);

endmodule
